// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - Shared widths, Horner coefficients and overflow reduction (POLY_DATAPATH_SAT_EN selects clamping)
package poly_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int N_TERMS = 4;

  // Q8.8 coefficients, index 0 is the constant term: 1.0 + 1.0x + 0.5x^2 + 0.168x^3
  localparam logic signed [DATA_W-1:0] COEF [N_TERMS] = '{16'sd256, 16'sd256, 16'sd128, 16'sd43};

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DATA_W - 1));

  // Brings a wide signed intermediate back to DATA_W: clamp when saturation is built in, wrap otherwise
  function automatic logic signed [DATA_W-1:0] fx_reduce(input logic signed [63:0] v);
`ifdef POLY_DATAPATH_SAT_EN
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
`else
    logic signed [63:0] w_tmp;
    w_tmp = v;
    return w_tmp[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// rtl/fx_mul_sat.sv - Signed fixed-point multiply with floor shift and reduction (POLY_DATAPATH_SAT_EN selects clamping)
module fx_mul_sat #(
  parameter int DATA_W = poly_pkg::DATA_W,
  parameter int FRAC_W = poly_pkg::FRAC_W
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_p
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] w_shift;
  logic signed [63:0]         w_wide;

  // Full-precision product; arithmetic shift floors toward minus infinity
  always_comb begin
    w_prod  = i_a * i_b;
    w_shift = w_prod >>> FRAC_W;
    w_wide  = 64'(w_shift);
    o_p     = poly_pkg::fx_reduce(w_wide);
  end

endmodule

// File: rtl/poly_datapath.sv
// rtl/poly_datapath.sv - Horner-rule polynomial datapath driven by controller strobes (POLY_DATAPATH_SAT_EN selects clamping)
module poly_datapath #(
  parameter int DATA_W  = poly_pkg::DATA_W,
  parameter int FRAC_W  = poly_pkg::FRAC_W,
  parameter int N_TERMS = poly_pkg::N_TERMS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     read,
  input  logic                     load_y,
  input  logic                     select_y,
  input  logic                     mult,
  input  logic                     sum,
  input  logic                     done,
  output logic                     s,
  output logic                     state_enable,
  output logic signed [DATA_W-1:0] result,
  output logic                     result_valid,
  input  logic                     result_ready
);

  localparam int CNT_W = $clog2(N_TERMS);

  logic signed [DATA_W-1:0] r_x;
  logic signed [DATA_W-1:0] r_y;
  logic signed [DATA_W-1:0] r_p;
  logic signed [DATA_W-1:0] r_t;
  logic [CNT_W-1:0]         r_cnt;

  logic signed [DATA_W-1:0] w_prod;
  logic [CNT_W-1:0]         w_idx;
  logic signed [DATA_W-1:0] w_coef;
  logic signed [63:0]       w_sum_wide;
  logic signed [DATA_W-1:0] w_sum;

  fx_mul_sat #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_mul (
    .i_a(r_y),
    .i_b(r_x),
    .o_p(w_prod)
  );

  // Coefficient for the next Horner step; index clamps at 0 so a stray sum never reads out of range
  always_comb begin
    w_idx      = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
    w_coef     = poly_pkg::COEF[w_idx];
    w_sum_wide = 64'(r_p) + 64'(w_coef);
    w_sum      = poly_pkg::fx_reduce(w_sum_wide);
  end

  // Handshake and status outputs; result is forced quiet while reset is held so nothing partial escapes
  always_comb begin
    in_ready     = read;
    s            = (r_cnt == '0);
    state_enable = (read & in_valid) | (done & result_ready) | ~(read | done);
    result_valid = done & reset;
    result       = (done & reset) ? r_y : '0;
  end

  // Each strobe owns its registers, so overlapping strobes update independently without lock-up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_p   <= '0;
      r_t   <= '0;
      r_cnt <= '0;
    end else begin
      if (read && in_valid) begin
        r_x <= x_in;
      end
      if (mult) begin
        r_p <= w_prod;
      end
      if (sum) begin
        r_t <= w_sum;
      end
      if (load_y) begin
        if (select_y) begin
          r_y   <= r_t;
          r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        end else begin
          r_y   <= poly_pkg::COEF[N_TERMS-1];
          r_cnt <= CNT_W'(N_TERMS - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_datapath.sv
// tb/tb_poly_datapath.sv - Scoreboard bench for poly_datapath (expectations follow POLY_DATAPATH_SAT_EN)
module tb_poly_datapath;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] x_in;
  logic               in_valid, in_ready, read, load_y, select_y, mult, sum, done;
  logic               s, state_enable, result_valid, result_ready;
  logic signed [15:0] result;

  typedef struct {
    logic [15:0] val;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks   = 0;
  int   failures = 0;
  int   lat      = 0;

  poly_datapath dut (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .read(read), .load_y(load_y), .select_y(select_y), .mult(mult), .sum(sum), .done(done),
    .s(s), .state_enable(state_enable), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle_strobes();
    read = 1'b0; in_valid = 1'b0; load_y = 1'b0; select_y = 1'b0;
    mult = 1'b0; sum = 1'b0; done = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_strobes();
  endtask

  // One full Horner sequence; expected value and latency are queued before the stimulus starts
  task automatic run_poly(input logic [15:0] x, input logic [15:0] req, input int stall, input bit do_read);
    sb.push_back('{req, do_read ? 12 + stall : -1});
    x_in = x;
    read = 1'b1; in_valid = do_read; cyc();
    load_y = 1'b1; select_y = 1'b0; cyc();
    for (int k = 0; k < 3; k++) begin
      mult = 1'b1; cyc();
      sum = 1'b1; cyc();
      load_y = 1'b1; select_y = 1'b1; cyc();
      chk("s_after_load", 32'(s), 32'(k == 2));
    end
    done = 1'b1;
    result_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      #3;
      chk("stall_state_enable", 32'(state_enable), 32'd0);
      chk("stall_result", 32'(result), 32'(req));
      @(posedge clk);
      #1;
    end
    result_ready = 1'b1;
    cyc();
  endtask

  always @(negedge clk) begin
    if (read && in_valid) lat = 1;
    else lat++;
    if (result_valid && result_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", result);
      end else begin
        m_e = sb.pop_front();
        chk("result", 32'(result), 32'(m_e.val));
        if (m_e.lat >= 0) chk("latency", 32'(lat), 32'(m_e.lat));
      end
    end
  end

  initial begin
    idle_strobes();
    result_ready = 1'b1;
    x_in = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
    #1;
    chk("reset_result_valid", 32'(result_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_s", 32'(s), 32'd1);
    done = 1'b0; read = 1'b1;
    #1;
    chk("reset_in_ready_hi", 32'(in_ready), 32'd1);
    read = 1'b0;
    #1;
    chk("reset_in_ready_lo", 32'(in_ready), 32'd0);
    reset = 1'b1;
    cyc();

    run_poly(16'h0000, 16'h0100, 0, 1'b1);
    run_poly(16'h0100, 16'h02AB, 0, 1'b1);
    run_poly(16'hFF00, 16'h0055, 0, 1'b1);
`ifdef POLY_DATAPATH_SAT_EN
    run_poly(16'h7FFF, 16'h7FFF, 0, 1'b1);
`else
    run_poly(16'h7FFF, 16'h35FF, 0, 1'b1);
`endif
    run_poly(16'h0100, 16'h02AB, 5, 1'b1);

    // read with no valid operand must stall and keep x = 1.0 from the previous run
    read = 1'b1; in_valid = 1'b0; x_in = 16'hFF00;
    #1;
    chk("noval_state_enable", 32'(state_enable), 32'd0);
    chk("noval_in_ready", 32'(in_ready), 32'd1);
    cyc();
    run_poly(16'hFF00, 16'h02AB, 0, 1'b0);

    // reset during a multiply abandons the computation
    x_in = 16'h0100; read = 1'b1; in_valid = 1'b1; cyc();
    load_y = 1'b1; select_y = 1'b0; cyc();
    chk("pre_reset_s", 32'(s), 32'd0);
    mult = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_s", 32'(s), 32'd1);
    done = 1'b1;
    #1;
    chk("midreset_result_valid", 32'(result_valid), 32'd0);
    chk("midreset_result", 32'(result), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    run_poly(16'hFF00, 16'h0055, 0, 1'b1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_datapath.md
POLY_DATAPATH -- requirements
Module: poly_datapath

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 16, signed fixed-point word width.
- FRAC_W, 8, fractional bits (Q8.8 by default).
- N_TERMS, 4, polynomial coefficient count (>=2).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- x_in  in  DATA_W  signed operand x.
- in_valid  in  1  x_in valid.
- in_ready  out  1  x_in accepted this cycle.
- read  in  1  controller read-state strobe.
- load_y  in  1  controller load-y strobe.
- select_y  in  1  y source select (0 = top coefficient, 1 = sum register).
- mult  in  1  controller multiply strobe.
- sum  in  1  controller add strobe.
- done  in  1  controller done-state strobe.
- s  out  1  last iteration complete, to controller.
- state_enable  out  1  controller state-register enable.
- result  out  DATA_W  polynomial value P(x).
- result_valid  out  1  result offered.
- result_ready  in  1  consumer accepts result.
REQ-003 Clock SHALL be clk; reset SHALL be reset, asynchronous, active-low; no other clock or reset.

Function
REQ-004 Block SHALL evaluate P(x)=sum COEF[i]*x^i by Horner's rule, one control strobe set per cycle.
REQ-005 read & in_valid: x_reg <= x_in; in_ready = read (combinational).
REQ-006 load_y & !select_y: y_reg <= COEF[N_TERMS-1], cnt <= N_TERMS-1.
REQ-007 mult: p_reg <= (y_reg * x_reg) arithmetic-shifted right FRAC_W (floor), reduced to DATA_W per REQ-016.
REQ-008 sum: t_reg <= p_reg + COEF[cnt-1], reduced to DATA_W per REQ-016.
REQ-009 load_y & select_y: y_reg <= t_reg, cnt <= cnt-1.
REQ-010 s SHALL equal (cnt == 0), combinational.
REQ-011 state_enable = (read & in_valid) | (done & result_ready) | !(read | done).
REQ-012 done: result = y_reg, result_valid = 1; handshake completes on done & result_ready; result held stable while stalled.
REQ-013 Latency SHALL be 3 + 3*(N_TERMS-1) cycles from accepted x to result_valid cycle (12 at N_TERMS=4), excluding stalls.
REQ-014 Simultaneous strobes outside REQ-005..009 SHALL not occur; if they do, registers update per each strobe independently, no lock-up.
REQ-015 cnt SHALL never decrement below 0 (hold at 0).

Reset
REQ-016 (arith) Overflow handling per Configuration.
REQ-017 reset low SHALL immediately clear x_reg, y_reg, p_reg, t_reg, cnt to 0; result_valid=0, result=0, in_ready follows read.
REQ-018 reset mid-computation SHALL abandon it; no partial result is ever flagged valid.

Configuration
REQ-019 Macro POLY_DATAPATH_SAT_EN defined: multiply and add results exceeding DATA_W signed range SHALL clamp to max/min (0x7FFF/0x8000 at 16 bits).
REQ-020 Macro undefined: results SHALL wrap (two's-complement truncation to DATA_W).

Structure
REQ-021 Package poly_pkg SHALL hold DATA_W, FRAC_W, N_TERMS defaults and COEF constant array (default Q8.8 {256,256,128,43}, index 0 = constant term).
REQ-022 One sub-module fx_mul_sat SHALL implement multiply, shift and REQ-016 reduction; the adder reuses its reduction function from poly_pkg.

Verification
REQ-023 x_in=0x0000 full sequence -> result 0x0100 (256), latency 12 cycles.
REQ-024 x_in=0x0100 (1.0) -> result 683 (0x02AB); s rises only in the third load_y-with-select cycle.
REQ-025 x_in=0xFF00 (-1.0) -> result 85 (0x0055).
REQ-026 x_in=0x7FFF with POLY_DATAPATH_SAT_EN -> result 0x7FFF; without -> wrapped value matching model.
REQ-027 result_ready held 0 for 5 cycles in done -> state_enable=0, result stable; in_valid low in read -> state_enable=0, no register change.
REQ-028 reset asserted during mult cycle -> all registers 0 same cycle, result_valid 0, fresh x after release gives correct result.
